ber_checker: RTL and testbench

Synthesizable end-of-link checker that sits directly downstream of the BCH decoder.
- Buffers the transmitted reference bit stream (the generator's FIFO-write side) in an internal circular buffer.
- Compares each decoded bit against its reference bit, in order, and counts compared bits and mismatches.
- Signals DONE/PASS after a fixed number of bits.
- Replaces simulation-only vector bookkeeping so the link can be self-checked on hardware.

---
 rtl/ber_checker.sv | 172 +++++++++++++++++
 tb/tb_ber_checker.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ber_checker.sv
`default_nettype none
// ============================================================================
// Module   : ber_checker
// Purpose  : End-of-link BER checker. Buffers reference bits, compares decoded
//            bits in order, counts bits/errors, reports DONE/PASS.
//            Optional macro BER_CHECKER_FIRST_ERR_EN enables FIRST_ERR_IDX.
// Revision : 1.0 - initial release
// ============================================================================
module ber_checker #(
    parameter int BUF_DEPTH  = 256,
    parameter int CNT_WIDTH  = 32,
    parameter int CHECK_BITS = 200,
    parameter int ERR_THRESH = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic                 tx_data_i,
    input  logic                 tx_valid_i,
    input  logic                 rx_data_i,
    input  logic                 rx_valid_i,
    output logic [CNT_WIDTH-1:0] bit_count_o,
    output logic [CNT_WIDTH-1:0] err_count_o,
    output logic                 tx_overflow_o,
    output logic                 rx_underflow_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic [CNT_WIDTH-1:0] first_err_idx_o
);

    localparam int                 c_AW     = $clog2(BUF_DEPTH);
    localparam logic [c_AW:0]      c_DEPTH  = (c_AW+1)'(BUF_DEPTH);
    localparam logic [c_AW:0]      c_OCC1   = (c_AW+1)'(1);
    localparam logic [c_AW-1:0]    c_PTR1   = c_AW'(1);
    localparam logic [CNT_WIDTH-1:0] c_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] c_MAX   = '1;
    localparam logic [CNT_WIDTH-1:0] c_CHECK = CNT_WIDTH'(CHECK_BITS);
    localparam logic [CNT_WIDTH-1:0] c_THRESH = CNT_WIDTH'(ERR_THRESH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [c_AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [c_AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [c_AW:0]          occ_q, occ_d;
    logic [CNT_WIDTH-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_WIDTH-1:0]   err_cnt_q, err_cnt_d;
    logic                   ovf_q, ovf_d;
    logic                   udf_q, udf_d;
    logic                   pass_q, pass_d;
    logic                   mem_q [BUF_DEPTH];

    logic w_run, w_full, w_empty, w_wr, w_rd, w_bypass, w_cmp, w_ref, w_mis;

    assign w_run    = (state_q == S_RUN);
    assign w_full   = (occ_q == c_DEPTH);
    assign w_empty  = (occ_q == '0);
    // With both valids the write only needs a free slot after the read, so a
    // full buffer still accepts; an empty buffer bypasses the store entirely.
    assign w_wr     = w_run && tx_valid_i && (rx_valid_i ? !w_empty : !w_full);
    assign w_rd     = w_run && rx_valid_i && !w_empty;
    assign w_bypass = w_run && tx_valid_i && rx_valid_i && w_empty;
    assign w_cmp    = w_rd || w_bypass;
    assign w_ref    = w_bypass ? tx_data_i : mem_q[rd_ptr_q];
    assign w_mis    = w_cmp && (rx_data_i != w_ref);

`ifdef BER_CHECKER_FIRST_ERR_EN
    logic [CNT_WIDTH-1:0] first_q, first_d;
`endif

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        occ_d     = occ_q;
        bit_cnt_d = bit_cnt_q;
        err_cnt_d = err_cnt_q;
        ovf_d     = ovf_q;
        udf_d     = udf_q;
        pass_d    = pass_q;
`ifdef BER_CHECKER_FIRST_ERR_EN
        first_d   = first_q;
`endif
        if (!w_run) begin
            if (start_i) begin
                state_d   = S_RUN;
                wr_ptr_d  = '0;
                rd_ptr_d  = '0;
                occ_d     = '0;
                bit_cnt_d = '0;
                err_cnt_d = '0;
                ovf_d     = 1'b0;
                udf_d     = 1'b0;
                pass_d    = 1'b0;
`ifdef BER_CHECKER_FIRST_ERR_EN
                first_d   = '0;
`endif
            end
        end else begin
            if (w_wr) wr_ptr_d = wr_ptr_q + c_PTR1;
            if (w_rd) rd_ptr_d = rd_ptr_q + c_PTR1;
            if (w_wr && !w_rd)      occ_d = occ_q + c_OCC1;
            else if (w_rd && !w_wr) occ_d = occ_q - c_OCC1;
            if (tx_valid_i && !rx_valid_i && w_full)  ovf_d = 1'b1;
            if (rx_valid_i && !tx_valid_i && w_empty) udf_d = 1'b1;
            if (w_cmp && bit_cnt_q != c_MAX) bit_cnt_d = bit_cnt_q + c_ONE;
            if (w_mis && err_cnt_q != c_MAX) err_cnt_d = err_cnt_q + c_ONE;
`ifdef BER_CHECKER_FIRST_ERR_EN
            if (w_mis && err_cnt_q == '0) first_d = bit_cnt_q;
`endif
            if (w_cmp && bit_cnt_d == c_CHECK) begin
                state_d = S_DONE;
                pass_d  = (err_cnt_d <= c_THRESH) && !ovf_d && !udf_d;
`ifdef BER_CHECKER_FIRST_ERR_EN
                if (err_cnt_d == '0) first_d = '1;
`endif
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            bit_cnt_q <= '0;
            err_cnt_q <= '0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            bit_cnt_q <= bit_cnt_d;
            err_cnt_q <= err_cnt_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            pass_q    <= pass_d;
        end
    end

    // Storage holds no state that matters after reset; occupancy gates reads.
    always_ff @(posedge clk_i) begin
        if (w_wr) mem_q[wr_ptr_q] <= tx_data_i;
    end

`ifdef BER_CHECKER_FIRST_ERR_EN
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) first_q <= '0;
        else         first_q <= first_d;
    end
    assign first_err_idx_o = first_q;
`else
    assign first_err_idx_o = '0;
`endif

    assign bit_count_o    = bit_cnt_q;
    assign err_count_o    = err_cnt_q;
    assign tx_overflow_o  = ovf_q;
    assign rx_underflow_o = udf_q;
    assign done_o         = (state_q == S_DONE);
    assign pass_o         = pass_q;

endmodule
`default_nettype wire

// File: tb/tb_ber_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_ber_checker
// Purpose  : Directed self-checking bench for ber_checker (default build and a
//            BUF_DEPTH=4 / CHECK_BITS=4 instance).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ber_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, tx_d = 1'b0, tx_v = 1'b0, rx_d = 1'b0, rx_v = 1'b0;
    logic [31:0] bit_cnt, err_cnt, first_idx;
    logic        ovf, udf, done, pass;

    logic        start4 = 1'b0, tx_d4 = 1'b0, tx_v4 = 1'b0, rx_d4 = 1'b0, rx_v4 = 1'b0;
    logic [31:0] bit_cnt4, err_cnt4, first_idx4;
    logic        ovf4, udf4, done4, pass4;

    int n_cmp = 0;
    int n_err = 0;
    logic pat [200];

    always #5 clk = ~clk;

    ber_checker dut (
        .clk_i(clk), .reset_i(rst), .start_i(start),
        .tx_data_i(tx_d), .tx_valid_i(tx_v), .rx_data_i(rx_d), .rx_valid_i(rx_v),
        .bit_count_o(bit_cnt), .err_count_o(err_cnt),
        .tx_overflow_o(ovf), .rx_underflow_o(udf),
        .done_o(done), .pass_o(pass), .first_err_idx_o(first_idx)
    );

    ber_checker #(.BUF_DEPTH(4), .CNT_WIDTH(32), .CHECK_BITS(4), .ERR_THRESH(2)) dut4 (
        .clk_i(clk), .reset_i(rst), .start_i(start4),
        .tx_data_i(tx_d4), .tx_valid_i(tx_v4), .rx_data_i(rx_d4), .rx_valid_i(rx_v4),
        .bit_count_o(bit_cnt4), .err_count_o(err_cnt4),
        .tx_overflow_o(ovf4), .rx_underflow_o(udf4),
        .done_o(done4), .pass_o(pass4), .first_err_idx_o(first_idx4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // 200 reference bits, RX delayed 40 cycles; bits listed in flips inverted on RX.
    task automatic run_traffic(input int f0, input int f1, input int f2);
        for (int c = 0; c < 240; c++) begin
            tx_v = (c < 200);
            tx_d = (c < 200) ? pat[c] : 1'b0;
            rx_v = (c >= 40);
            rx_d = 1'b0;
            if (c >= 40)
                rx_d = pat[c-40] ^ ((c-40) == f0 || (c-40) == f1 || (c-40) == f2);
            step();
            if (c == 238) begin
                n_cmp++;
                if (bit_cnt !== 32'd199 || done !== 1'b0) begin
                    n_err++;
                    $display("FAIL pre_done: bit_count=%0d done=%b, required 199/0", bit_cnt, done);
                end
            end
        end
        tx_v = 1'b0; rx_v = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) step();
        n_cmp++;
        if ({bit_cnt, err_cnt, ovf, udf, done, pass, first_idx} !== '0) begin
            n_err++;
            $display("FAIL reset_state: bit=%0d err=%0d ovf=%b udf=%b done=%b pass=%b, required all 0",
                     bit_cnt, err_cnt, ovf, udf, done, pass);
        end
        rst = 1'b0;
        step();
        pulse_start();
        for (int i = 0; i < 50; i++) begin
            tx_v = 1'b1; rx_v = 1'b1; tx_d = i[0]; rx_d = i[0];
            step();
        end
        tx_v = 1'b0; rx_v = 1'b0;
        n_cmp++;
        if (bit_cnt !== 32'd50) begin
            n_err++;
            $display("FAIL bypass_50: bit_count=%0d, required 50", bit_cnt);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({bit_cnt, err_cnt, ovf, udf, done, pass, first_idx} !== '0) begin
            n_err++;
            $display("FAIL async_reset: bit_count=%0d done=%b, required 0/0", bit_cnt, done);
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rx_v = 1'b1; rx_d = 1'b1;
            step();
        end
        rx_v = 1'b0;
        n_cmp++;
        if (bit_cnt !== 32'd0 || udf !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL idle_ignore: bit=%0d udf=%b done=%b, required 0/0/0", bit_cnt, udf, done);
        end
    endtask

    task automatic test_match();
        pulse_start();
        run_traffic(-1, -1, -1);
        n_cmp++;
        if (bit_cnt !== 32'd200 || err_cnt !== 32'd0) begin
            n_err++;
            $display("FAIL match_counts: bit=%0d err=%0d, required 200/0", bit_cnt, err_cnt);
        end
        n_cmp++;
        if (done !== 1'b1 || pass !== 1'b1) begin
            n_err++;
            $display("FAIL match_result: done=%b pass=%b, required 1/1", done, pass);
        end
`ifdef BER_CHECKER_FIRST_ERR_EN
        n_cmp++;
        if (first_idx !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL match_first_idx: got %h, required ffffffff", first_idx);
        end
`endif
    endtask

    task automatic test_errors();
        pulse_start();
        n_cmp++;
        if (done !== 1'b0 || pass !== 1'b0 || bit_cnt !== 32'd0) begin
            n_err++;
            $display("FAIL restart_clear: done=%b pass=%b bit=%0d, required 0/0/0", done, pass, bit_cnt);
        end
        run_traffic(10, 77, 150);
        n_cmp++;
        if (bit_cnt !== 32'd200 || err_cnt !== 32'd3) begin
            n_err++;
            $display("FAIL err_counts: bit=%0d err=%0d, required 200/3", bit_cnt, err_cnt);
        end
        n_cmp++;
        if (done !== 1'b1 || pass !== 1'b0) begin
            n_err++;
            $display("FAIL err_result: done=%b pass=%b, required 1/0", done, pass);
        end
        n_cmp++;
`ifdef BER_CHECKER_FIRST_ERR_EN
        if (first_idx !== 32'd10) begin
            n_err++;
            $display("FAIL first_idx: got %0d, required 10", first_idx);
        end
`else
        if (first_idx !== 32'd0) begin
            n_err++;
            $display("FAIL first_idx: got %0d, required 0", first_idx);
        end
`endif
        for (int i = 0; i < 4; i++) begin
            tx_v = 1'b1; rx_v = 1'b1; tx_d = 1'b0; rx_d = 1'b1;
            step();
        end
        tx_v = 1'b0; rx_v = 1'b0;
        n_cmp++;
        if (bit_cnt !== 32'd200 || err_cnt !== 32'd3 || done !== 1'b1) begin
            n_err++;
            $display("FAIL done_hold: bit=%0d err=%0d done=%b, required 200/3/1", bit_cnt, err_cnt, done);
        end
    endtask

    task automatic test_restart();
        pulse_start();
        n_cmp++;
        if ({bit_cnt, err_cnt, ovf, udf, done, pass, first_idx} !== '0) begin
            n_err++;
            $display("FAIL restart_from_done: bit=%0d err=%0d done=%b first=%0d, required all 0",
                     bit_cnt, err_cnt, done, first_idx);
        end
        run_traffic(-1, -1, -1);
        n_cmp++;
        if (done !== 1'b1 || pass !== 1'b1 || err_cnt !== 32'd0) begin
            n_err++;
            $display("FAIL restart_result: done=%b pass=%b err=%0d, required 1/1/0", done, pass, err_cnt);
        end
    endtask

    task automatic test_overflow();
        logic [4:0] bits;
        bits = 5'b01101;
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tx_v4 = 1'b1; tx_d4 = bits[i];
            step();
            if (i == 3) begin
                n_cmp++;
                if (ovf4 !== 1'b0) begin
                    n_err++;
                    $display("FAIL ovf_early: tx_overflow=%b after 4 bits, required 0", ovf4);
                end
            end
        end
        tx_v4 = 1'b0;
        n_cmp++;
        if (ovf4 !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_set: tx_overflow=%b, required 1", ovf4);
        end
        for (int i = 0; i < 4; i++) begin
            rx_v4 = 1'b1; rx_d4 = bits[i];
            step();
            if (i == 2) begin
                n_cmp++;
                if (done4 !== 1'b0 || bit_cnt4 !== 32'd3) begin
                    n_err++;
                    $display("FAIL ovf_partial: done=%b bit=%0d, required 0/3", done4, bit_cnt4);
                end
            end
        end
        rx_v4 = 1'b0;
        n_cmp++;
        if (done4 !== 1'b1 || pass4 !== 1'b0 || err_cnt4 !== 32'd0 || bit_cnt4 !== 32'd4) begin
            n_err++;
            $display("FAIL ovf_result: done=%b pass=%b err=%0d bit=%0d, required 1/0/0/4",
                     done4, pass4, err_cnt4, bit_cnt4);
        end
    endtask

    task automatic test_underflow();
        pulse_start();
        rx_v = 1'b1; rx_d = 1'b1;
        step();
        rx_v = 1'b0;
        n_cmp++;
        if (udf !== 1'b1 || bit_cnt !== 32'd0) begin
            n_err++;
            $display("FAIL udf_set: udf=%b bit=%0d, required 1/0", udf, bit_cnt);
        end
        tx_v = 1'b1; rx_v = 1'b1; tx_d = 1'b1; rx_d = 1'b1;
        step();
        tx_v = 1'b0; rx_v = 1'b0;
        n_cmp++;
        if (bit_cnt !== 32'd1 || err_cnt !== 32'd0) begin
            n_err++;
            $display("FAIL bypass: bit=%0d err=%0d, required 1/0", bit_cnt, err_cnt);
        end
        rx_v = 1'b1; rx_d = 1'b1;
        step();
        rx_v = 1'b0;
        n_cmp++;
        if (bit_cnt !== 32'd1 || ovf !== 1'b0) begin
            n_err++;
            $display("FAIL bypass_no_store: bit=%0d ovf=%b, required 1/0", bit_cnt, ovf);
        end
    endtask

    initial begin
        logic [15:0] lfsr;
        lfsr = 16'hACE1;
        for (int i = 0; i < 200; i++) begin
            pat[i] = lfsr[0];
            lfsr   = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        end
        test_reset();
        test_match();
        test_errors();
        test_restart();
        test_overflow();
        test_underflow();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
